// File: rtl/shift_iter_pkg.sv
// ============================================================================
// shift_iter_pkg : shift mode and FSM state encodings, per-clock step limit
// Revision 1.0
// ============================================================================
`default_nettype none

package shift_iter_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam int STEP_MAX = 3;

endpackage

`default_nettype wire

// File: rtl/shift_iter_step.sv
// ============================================================================
// shift_iter_step : combinational 0-3 position shift, one 4:1 mux per bit
// Revision 1.0
// ============================================================================
`default_nettype none

module shift_iter_step
  import shift_iter_pkg::*;
#(
  parameter int WIDTH = 65
) (
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       amt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [3:0] cand;

    for (genvar k = 0; k < 4; k++) begin : g_amt
      logic left_bit;
      logic right_bit;

      if (i >= k) begin : g_left_in
        assign left_bit = a[i-k];
      end else begin : g_left_fill
        assign left_bit = 1'b0;
      end

      // Past the MSB a right shift takes its wrap bit, sign bit or zero.
      if (i + k < WIDTH) begin : g_right_in
        assign right_bit = a[i+k];
      end else begin : g_right_fill
        assign right_bit = (mode == MODE_ROR) ? a[i+k-WIDTH] :
                           (mode == MODE_ASR) ? a[WIDTH-1]   : 1'b0;
      end

      assign cand[k] = (mode == MODE_LSL) ? left_bit : right_bit;
    end

    assign y[i] = cand[amt];
  end

endmodule

`default_nettype wire

// File: rtl/shift_iter.sv
// ============================================================================
// shift_iter : iterative LSL/LSR/ASR/ROR shifter, up to 3 positions per clock
// Revision 1.0
// ============================================================================
`default_nettype none

module shift_iter
  import shift_iter_pkg::*;
#(
  parameter int WIDTH   = 65,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   d_out,
  output logic               busy,
  output logic               done
);

  state_e             state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] rem;
  logic [1:0]         mode_r;
  logic [1:0]         step;
  logic [WIDTH-1:0]   acc_next;

  assign step = (rem > SHAMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : rem[1:0];

  shift_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a    (acc),
    .amt  (step),
    .mode (mode_r),
    .y    (acc_next)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state  <= ST_IDLE;
      acc    <= '0;
      rem    <= '0;
      mode_r <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            acc    <= d_in;
            rem    <= shamt;
            mode_r <= mode;
            if (shamt != '0) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          acc <= acc_next;
          rem <= rem - SHAMT_W'(step);
          // Final step is the one that consumes exactly what is left.
          if (rem == SHAMT_W'(step)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign d_out = acc;

endmodule

`default_nettype wire
